pipe_tag_source: RTL

Client-side companion to the sized FIFO. It drains a FIFO's PipeOut port (`first`/`deq`), prepends a 16-bit frame tag to each item, and enqueues the result into a downstream PipeIn port of width `16 + width`. A one-entry holding register decouples the two handshakes and sustains one item per cycle.

---
 rtl/pipe_tag_source.sv | 71 +++++++
 1 files changed

// File: rtl/pipe_tag_source.sv
// Drains a FIFO PipeOut port, prepends a 16-bit frame tag and enqueues into a PipeIn port.
// Optional PIPE_TAG_PARITY_EN: tag bit 13 carries even parity over the captured data.
module pipe_tag_source #(
   parameter int width    = 128,
   parameter int frameLen = 8
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic [width-1:0]   src_first,
   input  logic               src_first__RDY,
   input  logic               src_deq__RDY,
   output logic               src_deq__ENA,
   output logic               dst_enq__ENA,
   output logic [width+15:0]  dst_enq_v,
   input  logic               dst_enq__RDY
);

   localparam logic [7:0] LAST_BEAT = 8'(frameLen - 1);

   typedef enum logic {EMPTY, FULL} hold_state_t;

   hold_state_t        hold_st;
   logic               hold_v;
   logic [width-1:0]   hold_data;
   logic [15:0]        hold_tag;
   logic [11:0]        seq;
   logic [7:0]         beat;

   logic               cap;
   logic               enq_fire;
   logic               cap_par;
   logic [15:0]        cap_tag;

   assign hold_v   = (hold_st == FULL);
   assign enq_fire = hold_v & dst_enq__RDY;
   // A full holder may refill in the same cycle it drains; this is what sustains full rate.
   assign cap      = src_first__RDY & src_deq__RDY & (!hold_v | dst_enq__RDY);

   assign src_deq__ENA = cap & nRST;
   assign dst_enq__ENA = enq_fire & nRST;
   assign dst_enq_v    = {hold_tag, hold_data};

`ifdef PIPE_TAG_PARITY_EN
   assign cap_par = ^src_first;
`else
   assign cap_par = 1'b0;
`endif

   assign cap_tag = {(beat == 8'd0), (beat == LAST_BEAT), cap_par, 1'b0, seq};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hold_st   <= EMPTY;
         hold_data <= '0;
         hold_tag  <= '0;
         seq       <= '0;
         beat      <= '0;
      end else begin
         if (cap) begin
            hold_st   <= FULL;
            hold_data <= src_first;
            hold_tag  <= cap_tag;
            seq       <= seq + 12'd1;
            beat      <= (beat == LAST_BEAT) ? 8'd0 : beat + 8'd1;
         end else if (enq_fire) begin
            hold_st   <= EMPTY;
         end
      end
   end

endmodule
